// File: rtl/uart_rx_bit_timer_if.sv
// Serial receive timing bundle: raw line in, per-bit strobes and frame status flags out.
// The master side is the bit timer; the slave side is the line driver and downstream shift stage.
interface uart_rx_bit_timer_if;
  logic rx;
  logic sample_en;
  logic bit_out;
  logic busy;
  logic frame_done;
  logic frame_err;

  modport master (
    input  rx,
    output sample_en,
    output bit_out,
    output busy,
    output frame_done,
    output frame_err
  );

  modport slave (
    output rx,
    input  sample_en,
    input  bit_out,
    input  busy,
    input  frame_done,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// UART receive bit timer: synchronizes rx, validates the start bit and emits one mid-bit
// strobe per frame bit, with done/error flags aligned to the downstream shift stage output.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_rx_bit_timer_if.master   bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bitn_r;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             sample_en_r;
  logic             bit_out_r;
  logic             busy_r;
  logic             done_arm_r;
  logic             err_arm_r;
  logic             done_dly_r;
  logic             err_dly_r;
  logic             frame_done_r;
  logic             frame_err_r;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Framing FSM with bit-period counter and registered strobe/bit/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bitn_r      <= 3'd0;
      sample_en_r <= 1'b0;
      bit_out_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_arm_r  <= 1'b0;
      err_arm_r   <= 1'b0;
    end else begin
      sample_en_r <= 1'b0;
      done_arm_r  <= 1'b0;
      err_arm_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r <= START;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= '0;
            if (!rx_sync_r) begin
              sample_en_r <= 1'b1;
              bit_out_r   <= 1'b0;
              bitn_r      <= 3'd0;
              state_r     <= DATA;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r       <= '0;
            sample_en_r <= 1'b1;
            bit_out_r   <= rx_sync_r;
            if (bitn_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bitn_r <= bitn_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r       <= '0;
            sample_en_r <= 1'b1;
            bit_out_r   <= rx_sync_r;
            if (rx_sync_r) begin
              done_arm_r <= 1'b1;
              state_r    <= IDLE;
              busy_r     <= 1'b0;
            end else begin
              err_arm_r <= 1'b1;
              state_r   <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A line held low after a bad stop bit must not be mistaken for a new start
          if (rx_sync_r) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Delay the frame flags so they coincide with the shift stage's byte output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_dly_r   <= 1'b0;
      err_dly_r    <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      done_dly_r   <= done_arm_r;
      err_dly_r    <= err_arm_r;
      frame_done_r <= done_dly_r;
      frame_err_r  <= err_dly_r;
    end
  end

  assign bus.sample_en  = sample_en_r;
  assign bus.bit_out    = bit_out_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer: table of normal frames plus hand-written corner sequences,
// with a model of the downstream 10-bit shift stage to check the byte seen at frame_done.
module tb_uart_rx_bit_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_drv [2];

  always #5 clk = ~clk;

  uart_rx_bit_timer_if bus_a ();
  uart_rx_bit_timer_if bus_b ();

  assign bus_a.rx = rx_drv[0];
  assign bus_b.rx = rx_drv[1];

  uart_rx_bit_timer #(.CLKS_PER_BIT(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  uart_rx_bit_timer #(.CLKS_PER_BIT(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int cpb_v  [2] = '{8, 5};
  int half_v [2] = '{4, 2};

  logic se [2], bo [2], bz [2], fd [2], fe [2];
  assign se[0] = bus_a.sample_en;  assign se[1] = bus_b.sample_en;
  assign bo[0] = bus_a.bit_out;    assign bo[1] = bus_b.bit_out;
  assign bz[0] = bus_a.busy;       assign bz[1] = bus_b.busy;
  assign fd[0] = bus_a.frame_done; assign fd[1] = bus_b.frame_done;
  assign fe[0] = bus_a.frame_err;  assign fe[1] = bus_b.frame_err;

  // Downstream shift stage: shift on enable, byte register follows one cycle later
  logic [9:0] shreg [2];
  logic [7:0] outm  [2];
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        shreg[i] <= 10'd0;
        outm[i]  <= 8'd0;
      end else begin
        if (se[i]) shreg[i] <= {bo[i], shreg[i][9:1]};
        outm[i] <= shreg[i][8:1];
      end
    end
  end

  // Monitor: cumulative counters sampled on the falling edge
  int cyc = 0;
  int strobes [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int gap_bad [2] = '{0, 0};
  int overlap [2] = '{0, 0};
  int busy_rises [2] = '{0, 0};
  int busy_hi [2] = '{0, 0};
  int first_gap [2], done_gap [2], err_gap [2], last_strobe [2], start_cyc [2];
  logic busy_prev [2] = '{1'b0, 1'b0};
  logic first_pend [2] = '{1'b0, 1'b0};
  logic [9:0] cap [2];
  logic [7:0] done_out [2][16];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (bz[i] && !busy_prev[i]) begin
        busy_rises[i] = busy_rises[i] + 1;
        start_cyc[i]  = cyc;
        first_pend[i] = 1'b1;
      end
      if (bz[i]) busy_hi[i] = busy_hi[i] + 1;
      busy_prev[i] = bz[i];
      if (se[i]) begin
        strobes[i] = strobes[i] + 1;
        cap[i] = {bo[i], cap[i][9:1]};
        if (first_pend[i]) begin
          first_gap[i] = cyc - start_cyc[i];
          if (first_gap[i] != half_v[i]) gap_bad[i] = gap_bad[i] + 1;
          first_pend[i] = 1'b0;
        end else if (cyc - last_strobe[i] != cpb_v[i]) begin
          gap_bad[i] = gap_bad[i] + 1;
        end
        last_strobe[i] = cyc;
      end
      if (fd[i]) begin
        done_out[i][done_cnt[i] & 15] = outm[i];
        done_gap[i] = cyc - last_strobe[i];
        done_cnt[i] = done_cnt[i] + 1;
      end
      if (fe[i]) begin
        err_gap[i] = cyc - last_strobe[i];
        err_cnt[i] = err_cnt[i] + 1;
      end
      if (fd[i] && fe[i]) overlap[i] = overlap[i] + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv[d] = bits[i];
      repeat (cpb_v[d]) @(posedge clk);
      #1;
    end
  endtask

  int b_str, b_done, b_err, b_gap, b_rise, b_hi;
  task automatic snap(input int d);
    b_str  = strobes[d];
    b_done = done_cnt[d];
    b_err  = err_cnt[d];
    b_gap  = gap_bad[d];
    b_rise = busy_rises[d];
    b_hi   = busy_hi[d];
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk({tag, " sample_en"},  int'(se[d]), 0);
    chk({tag, " bit_out"},    int'(bo[d]), 1);
    chk({tag, " busy"},       int'(bz[d]), 0);
    chk({tag, " frame_done"}, int'(fd[d]), 0);
    chk({tag, " frame_err"},  int'(fe[d]), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_out;
  } frame_vec_t;

  frame_vec_t vec [4];

  initial begin
    vec[0] = '{data: 8'h41, exp_bits: 10'b1010000010, exp_done: 1, exp_err: 0, exp_out: 8'h41};
    vec[1] = '{data: 8'h80, exp_bits: 10'b1100000000, exp_done: 1, exp_err: 0, exp_out: 8'h80};
    vec[2] = '{data: 8'h00, exp_bits: 10'b1000000000, exp_done: 1, exp_err: 0, exp_out: 8'h00};
    vec[3] = '{data: 8'hC3, exp_bits: 10'b1110000110, exp_done: 1, exp_err: 0, exp_out: 8'hC3};

    rx_drv[0] = 1'b1;
    rx_drv[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "reset_a");
    chk_reset_outputs(1, "reset_b");
    idle(3);
    rst_n = 1'b1;
    idle(4);

    // Normal frames from the table on the CLKS_PER_BIT=8 instance
    for (int k = 0; k < 4; k++) begin
      snap(0);
      send_frame(0, vec[k].data, 1'b1);
      idle(16);
      chk($sformatf("vec%0d strobes", k), strobes[0] - b_str, 10);
      chk($sformatf("vec%0d bits", k), int'(cap[0]), int'(vec[k].exp_bits));
      chk($sformatf("vec%0d first_gap", k), first_gap[0], 4);
      chk($sformatf("vec%0d spacing", k), gap_bad[0] - b_gap, 0);
      chk($sformatf("vec%0d done", k), done_cnt[0] - b_done, vec[k].exp_done);
      chk($sformatf("vec%0d err", k), err_cnt[0] - b_err, vec[k].exp_err);
      chk($sformatf("vec%0d out", k), int'(done_out[0][b_done & 15]), int'(vec[k].exp_out));
      chk($sformatf("vec%0d done_gap", k), done_gap[0], 2);
      chk($sformatf("vec%0d busy_end", k), int'(bz[0]), 0);
    end

    // Glitch: two low cycles must be rejected at the half-bit check
    snap(0);
    rx_drv[0] = 1'b0;
    idle(2);
    rx_drv[0] = 1'b1;
    idle(20);
    chk("glitch strobes", strobes[0] - b_str, 0);
    chk("glitch busy_rises", busy_rises[0] - b_rise, 1);
    chk("glitch busy_cycles", busy_hi[0] - b_hi, 4);
    chk("glitch busy_end", int'(bz[0]), 0);
    chk("glitch done_err", (done_cnt[0] - b_done) + (err_cnt[0] - b_err), 0);

    // Framing error: stop bit low, line held low afterwards
    snap(0);
    send_frame(0, 8'h55, 1'b0);
    idle(20);
    chk("ferr strobes", strobes[0] - b_str, 10);
    chk("ferr bits", int'(cap[0]), int'(10'b0010101010));
    chk("ferr last_bit", int'(cap[0][9]), 0);
    chk("ferr err", err_cnt[0] - b_err, 1);
    chk("ferr err_gap", err_gap[0], 2);
    chk("ferr done", done_cnt[0] - b_done, 0);
    chk("ferr busy_wait", int'(bz[0]), 1);
    rx_drv[0] = 1'b1;
    idle(4);
    chk("ferr busy_after_high", int'(bz[0]), 0);
    chk("ferr busy_rises", busy_rises[0] - b_rise, 1);
    idle(8);

    // Back-to-back frames with no idle gap
    snap(0);
    send_frame(0, 8'hA5, 1'b1);
    send_frame(0, 8'h3C, 1'b1);
    idle(16);
    chk("b2b strobes", strobes[0] - b_str, 20);
    chk("b2b done", done_cnt[0] - b_done, 2);
    chk("b2b out0", int'(done_out[0][b_done & 15]), 8'hA5);
    chk("b2b out1", int'(done_out[0][(b_done + 1) & 15]), 8'h3C);
    chk("b2b spacing", gap_bad[0] - b_gap, 0);
    chk("b2b err", err_cnt[0] - b_err, 0);

    // Reset during data bit 4, then a clean frame
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h0F, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rx_drv[0] = bits[i];
        idle(8);
      end
      rx_drv[0] = bits[5];
      idle(6);
    end
    chk("rst_mid busy_before", int'(bz[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "rst_mid");
    rx_drv[0] = 1'b1;
    idle(3);
    snap(0);
    rst_n = 1'b1;
    idle(30);
    chk("rst_mid no_flags", (done_cnt[0] - b_done) + (err_cnt[0] - b_err), 0);
    chk("rst_mid no_strobes", strobes[0] - b_str, 0);
    snap(0);
    send_frame(0, 8'h0F, 1'b1);
    idle(16);
    chk("after_rst strobes", strobes[0] - b_str, 10);
    chk("after_rst bits", int'(cap[0]), int'(10'b1000011110));
    chk("after_rst done", done_cnt[0] - b_done, 1);
    chk("after_rst out", int'(done_out[0][b_done & 15]), 8'h0F);

    // Parameter corner: CLKS_PER_BIT=5
    snap(1);
    send_frame(1, 8'hFF, 1'b1);
    idle(12);
    chk("cpb5 strobes", strobes[1] - b_str, 10);
    chk("cpb5 first_gap", first_gap[1], 2);
    chk("cpb5 spacing", gap_bad[1] - b_gap, 0);
    chk("cpb5 done", done_cnt[1] - b_done, 1);
    chk("cpb5 out", int'(done_out[1][b_done & 15]), 8'hFF);
    chk("cpb5 done_gap", done_gap[1], 2);

    chk("overlap_a", overlap[0], 0);
    chk("overlap_b", overlap[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
# uart_rx_bit_timer

Bit-timing and framing controller for the serial receive path, placed directly upstream of the 10-bit receive shift register. It synchronizes the asynchronous serial line, detects and validates the start bit, and produces one mid-bit sample strobe plus the sampled bit value for each of the 10 frame bits (start, 8 data LSB-first, stop). Strobes and bit value drive the shift stage's `enable` and `ascii` inputs. The block also flags completed and malformed frames, aligned to the cycle in which the shift stage's `out` holds the byte.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per serial bit (50 MHz / 115200). Legal range is ≥ 4; `HALF` = `CLKS_PER_BIT/2`, rounded down.
- `clk`  input  1  system clock; everything updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `rx`  input  1  raw serial line; idles high; asynchronous to `clk`.
- `sample_en`  output  1  one-cycle strobe; connects to the shift stage `enable`.
- `bit_out`  output  1  sampled line value, valid while `sample_en`=1; connects to the shift stage `ascii`.
- `busy`  output  1  high in every state except IDLE.
- `frame_done`  output  1  one-cycle pulse: good frame, shift stage `out` valid this cycle.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.

## Operation
- Synchronizer: 2-FF chain on `rx` produces `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- Counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. It is cleared on every state entry. Bit counter `bitn` is 3 bits and counts data bits 0..7.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_s`=0, go to START with `cnt`=0.
  - START: increment `cnt`. At `cnt`=HALF-1:
    - if `rx_s`=0, assert strobe (bit_out=0), go to DATA with `bitn`=0;
    - otherwise (false start/glitch) return to IDLE with no strobe.
  - DATA: increment `cnt`. At `cnt`=CLKS_PER_BIT-1, assert strobe with `bit_out`=`rx_s` and clear `cnt`. After the strobe with `bitn`=7, go to STOP; otherwise increment `bitn`.
  - STOP: at `cnt`=CLKS_PER_BIT-1, assert strobe with `bit_out`=`rx_s`.
    - If `rx_s`=1: arm `frame_done` and go to IDLE.
    - If `rx_s`=0: arm `frame_err` and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A low line never starts a frame from here.
- Exactly 10 strobes per accepted frame. Zero strobes for a rejected start.
- `sample_en` and `bit_out` are registered outputs. `bit_out` holds its last value between strobes.
- `frame_done`/`frame_err` delay: the pulse is produced 2 cycles after the stop strobe cycle, through a 2-stage pipeline. This matches the shift stage: shift register updated at the end of strobe cycle T, `out` updated at the end of T+1, so `out` is valid in cycle T+2.
- A new start edge may be accepted in the cycle right after the STOP→IDLE transition. The delayed `frame_done` pulse from the previous frame still fires even if a new frame has begun.

## Timing
- Reset (asserted at any time, including mid-frame): state=IDLE, `cnt`=0, `bitn`=0, sync flops=1, `sample_en`=0, `bit_out`=1, `busy`=0, `frame_done`=0, `frame_err`=0, flag pipeline cleared. Any armed pulse is discarded.
- Start-detect latency: 2 cycles from the `rx` falling edge to `rx_s`, plus 1 cycle to enter START.
- First strobe: HALF cycles after entering START. Each following strobe is CLKS_PER_BIT cycles after the previous one.
- Strobe spacing is exact, with no drift across the frame.
- `busy` rises in the cycle START is entered. It falls in the cycle IDLE is re-entered. `busy` stays high throughout WAIT_IDLE.
- `frame_done` and `frame_err` are never high in the same cycle, and at most one of them fires per frame.

## Test plan
- **Normal frame.** CLKS_PER_BIT=8, send 0x41 ('A'); line bits are 0,1,0,0,0,0,0,1,0,1. Required: 10 `sample_en` pulses spaced 8 cycles apart, the first 4 cycles after entering START. `bit_out` matches the line bits in order. One `frame_done` 2 cycles after the last strobe, with the downstream shift stage `out`=8'h41. `frame_err` stays 0.
- **Glitch rejection.** `rx` low for 2 cycles, then high. Required: enters START, returns to IDLE at the half-bit check with no `sample_en`. `busy` pulses, then returns to 0.
- **Framing error.** Send 0x55 with the stop bit forced to 0, and hold `rx` low 20 more cycles. Required: 10 strobes, the last with `bit_out`=0. One `frame_err` pulse and no `frame_done`. No new START while `rx` stays low. The FSM returns to IDLE only after `rx` goes high.
- **Back-to-back frames.** Send 0xA5, then 0x3C, with the second start bit immediately after the first stop bit. Required: 20 strobes total and two `frame_done` pulses, with `out`=8'hA5 and then 8'h3C.
- **Reset mid-frame.** Pulse `rst_n` low during data bit 4. Required: all outputs reach their reset values immediately, asynchronously. No `frame_done`/`frame_err` for the aborted frame. The next full frame (0x0F) is received correctly.
- **Parameter corner.** CLKS_PER_BIT=5 (HALF=2), send 0xFF. Required: first strobe 2 cycles after entering START, then spacing of 5, and `frame_done` with `out`=8'hFF.
